stc_lt_array: RTL and testbench

//  N-channel clocked space-time "less-than" (inhibit) unit; parametrised successor of the async latch-based comparator.
//  Per channel, the first edge of a[i] in a gamma cycle passes to q[i] as a PULSE_WIDTH-cycle event only if a[i] is not later than b[i].

---
 rtl/stc_lt_array_pkg.sv | 15 +
 rtl/stc_lt_array_if.sv | 27 ++
 rtl/stc_lt_array_channel.sv | 114 +++++++++++
 rtl/stc_lt_array.sv | 66 ++++++
 tb/tb_stc_lt_array.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stc_lt_array_pkg.sv
// Shared types and helpers for the space-time less-than array.
// The STC_LT_TIMESTAMP_EN build option is handled in the files that import this package.
package stc_pkg;

  typedef enum logic [1:0] {ARMED, BLOCKED, FIRING, DONE} stc_lt_state_t;

  localparam int unsigned EDGE_MODE_RISE = 0;
  localparam int unsigned EDGE_MODE_FALL = 1;

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stc_lt_array_if.sv
// Bus bundle for stc_lt_array: inputs a/b/gamma_sync, outputs q and gamma position.
// t_fire/t_valid are present only when STC_LT_TIMESTAMP_EN is defined.
interface stc_lt_array_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned GW   = 4
);
  logic            gamma_sync;
  logic [N_CH-1:0] a;
  logic [N_CH-1:0] b;
  logic [N_CH-1:0] q;
  logic [GW-1:0]   gamma_cnt;
  logic            gamma_last;
`ifdef STC_LT_TIMESTAMP_EN
  logic [N_CH*GW-1:0] t_fire;
  logic [N_CH-1:0]    t_valid;

  modport master (output gamma_sync, a, b,
                  input  q, gamma_cnt, gamma_last, t_fire, t_valid);
  modport slave  (input  gamma_sync, a, b,
                  output q, gamma_cnt, gamma_last, t_fire, t_valid);
`else
  modport master (output gamma_sync, a, b,
                  input  q, gamma_cnt, gamma_last);
  modport slave  (input  gamma_sync, a, b,
                  output q, gamma_cnt, gamma_last);
`endif
endinterface

// File: rtl/stc_lt_array_channel.sv
// One less-than channel: edge detect, ARMED/BLOCKED/FIRING/DONE FSM, pulse counter.
// Optional gamma-position capture when STC_LT_TIMESTAMP_EN is defined.
module stc_lt_channel
  import stc_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned EDGE_FALLING      = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boundary,
  input  logic a,
  input  logic b,
`ifdef STC_LT_TIMESTAMP_EN
  input  logic [cnt_width(GAMMA_CYCLE_WIDTH)-1:0] gamma_cnt,
  output logic [cnt_width(GAMMA_CYCLE_WIDTH)-1:0] t_fire,
  output logic                                    t_valid,
`endif
  output logic q
);

  localparam int unsigned GW      = cnt_width(GAMMA_CYCLE_WIDTH);
  localparam int unsigned PCW     = cnt_width(PULSE_WIDTH);
  localparam logic [PCW-1:0] PC_LOAD = PCW'(PULSE_WIDTH - 1);
  localparam logic IDLE = (EDGE_FALLING == EDGE_MODE_FALL) ? 1'b1 : 1'b0;

  stc_lt_state_t  state, state_n;
  logic [PCW-1:0] pcnt, pcnt_n;
  logic           q_n;
  logic           a_prev, b_prev;
  logic           a_edge, b_edge;
`ifdef STC_LT_TIMESTAMP_EN
  logic [GW-1:0]  t_fire_n;
  logic           t_valid_n;
`endif

  // Active transition from the idle level toward the opposite level.
  assign a_edge = (a_prev == IDLE) && (a != IDLE);
  assign b_edge = (b_prev == IDLE) && (b != IDLE);

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    q_n     = IDLE;
`ifdef STC_LT_TIMESTAMP_EN
    t_fire_n  = t_fire;
    t_valid_n = t_valid;
`endif
    if (boundary) begin
      state_n = ARMED;
      pcnt_n  = '0;
`ifdef STC_LT_TIMESTAMP_EN
      t_fire_n  = '0;
      t_valid_n = 1'b0;
`endif
    end else begin
      unique case (state)
        ARMED: begin
          // a wins a same-cycle tie with b
          if (a_edge) begin
            state_n = FIRING;
            pcnt_n  = PC_LOAD;
            q_n     = ~IDLE;
`ifdef STC_LT_TIMESTAMP_EN
            t_fire_n  = gamma_cnt;
            t_valid_n = 1'b1;
`endif
          end else if (b_edge) begin
            state_n = BLOCKED;
          end
        end
        FIRING: begin
          if (pcnt == '0) begin
            state_n = DONE;
          end else begin
            pcnt_n = pcnt - PCW'(1);
            q_n    = ~IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARMED;
      pcnt   <= '0;
      q      <= IDLE;
      a_prev <= IDLE;
      b_prev <= IDLE;
    end else begin
      state  <= state_n;
      pcnt   <= pcnt_n;
      q      <= q_n;
      a_prev <= a;
      b_prev <= b;
    end
  end

`ifdef STC_LT_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_fire  <= '0;
      t_valid <= 1'b0;
    end else begin
      t_fire  <= t_fire_n;
      t_valid <= t_valid_n;
    end
  end
`endif

endmodule

// File: rtl/stc_lt_array.sv
// N-channel clocked space-time less-than unit: gamma counter, boundary decode, channel array.
// Define STC_LT_TIMESTAMP_EN to add per-channel t_fire/t_valid capture.
module stc_lt_array
  import stc_pkg::*;
#(
  parameter int unsigned N_CH              = 4,
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned EDGE_FALLING      = 0
) (
  input logic          clk,
  input logic          rst_n,
  stc_lt_array_if.slave bus
);

  localparam int unsigned    GW       = cnt_width(GAMMA_CYCLE_WIDTH);
  localparam logic [GW-1:0]  CNT_LAST = GW'(GAMMA_CYCLE_WIDTH - 1);

  logic [GW-1:0]   cnt;
  logic            last;
  logic            boundary;
  logic [N_CH-1:0] q_w;
`ifdef STC_LT_TIMESTAMP_EN
  logic [N_CH*GW-1:0] tf_w;
  logic [N_CH-1:0]    tv_w;
`endif

  assign last     = (cnt == CNT_LAST);
  assign boundary = last | bus.gamma_sync;

  // Sync and wrap both land on zero, so one boundary term covers both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (boundary) cnt <= '0;
    else               cnt <= cnt + GW'(1);
  end

  assign bus.gamma_cnt  = cnt;
  assign bus.gamma_last = last;
  assign bus.q          = q_w;
`ifdef STC_LT_TIMESTAMP_EN
  assign bus.t_fire  = tf_w;
  assign bus.t_valid = tv_w;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    stc_lt_channel #(
      .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
      .PULSE_WIDTH       (PULSE_WIDTH),
      .EDGE_FALLING      (EDGE_FALLING)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .boundary  (boundary),
      .a         (bus.a[i]),
      .b         (bus.b[i]),
`ifdef STC_LT_TIMESTAMP_EN
      .gamma_cnt (cnt),
      .t_fire    (tf_w[i*GW +: GW]),
      .t_valid   (tv_w[i]),
`endif
      .q         (q_w[i])
    );
  end

endmodule

// File: tb/tb_stc_lt_array.sv
// Bench for stc_lt_array: rising-edge and falling-edge instances, directed scenarios
// plus random traffic against a per-gamma-window first-edge-time model.
module tb_stc_lt_array;
  import stc_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned G  = 16;
  localparam int unsigned PW = 4;
  localparam int unsigned GW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n_r, rst_n_f;
  logic [N-1:0] ia [2];
  logic [N-1:0] ib [2];
  logic         isync [2];
  int           n_pass = 0;
  int           n_total = 0;

  stc_lt_array_if #(.N_CH(N), .GW(GW)) if_r ();
  stc_lt_array_if #(.N_CH(N), .GW(GW)) if_f ();

  assign if_r.a = ia[0];
  assign if_r.b = ib[0];
  assign if_r.gamma_sync = isync[0];
  assign if_f.a = ia[1];
  assign if_f.b = ib[1];
  assign if_f.gamma_sync = isync[1];

  stc_lt_array #(.N_CH(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .EDGE_FALLING(0))
    dut_r (.clk(clk), .rst_n(rst_n_r), .bus(if_r.slave));
  stc_lt_array #(.N_CH(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .EDGE_FALLING(1))
    dut_f (.clk(clk), .rst_n(rst_n_f), .bus(if_f.slave));

  // Model: per window, cycle index of first a-edge and first b-edge; pass iff ta <= tb.
  bit mpa [2][N];
  bit mpb [2][N];
  int mta [2][N];
  int mtb [2][N];
  int mtf [2][N];
  int ms  [2];
  int mcnt[2];

  task automatic model_reset(input int d);
    for (int i = 0; i < N; i++) begin
      mpa[d][i] = (d == 1);
      mpb[d][i] = (d == 1);
      mta[d][i] = -1;
      mtb[d][i] = -1;
      mtf[d][i] = 0;
    end
    ms[d]   = 0;
    mcnt[d] = 0;
  endtask

  task automatic model_step(input int d, input logic rstn);
    bit bnd, ea, eb;
    if (!rstn) begin
      model_reset(d);
      return;
    end
    bnd = (mcnt[d] == G - 1) || isync[d];
    for (int i = 0; i < N; i++) begin
      ea = (d == 1) ? (mpa[d][i] && !ia[d][i]) : (!mpa[d][i] && ia[d][i]);
      eb = (d == 1) ? (mpb[d][i] && !ib[d][i]) : (!mpb[d][i] && ib[d][i]);
      if (!bnd && ea && mta[d][i] < 0) begin
        mta[d][i] = ms[d];
        mtf[d][i] = mcnt[d];
      end
      if (!bnd && eb && mtb[d][i] < 0) mtb[d][i] = ms[d];
      mpa[d][i] = ia[d][i];
      mpb[d][i] = ib[d][i];
    end
    if (bnd) begin
      ms[d] = 0;
      mcnt[d] = 0;
      for (int i = 0; i < N; i++) begin
        mta[d][i] = -1;
        mtb[d][i] = -1;
      end
    end else begin
      ms[d]++;
      mcnt[d]++;
    end
  endtask

  function automatic bit mpass(input int d, input int i);
    return (mta[d][i] >= 0) && (mtb[d][i] < 0 || mta[d][i] <= mtb[d][i]);
  endfunction

  function automatic logic [N-1:0] exp_q(input int d);
    logic [N-1:0] r;
    bit act;
    for (int i = 0; i < N; i++) begin
      act = mpass(d, i) && ms[d] >= mta[d][i] + 1 && ms[d] <= mta[d][i] + int'(PW);
      r[i] = (d == 1) ? !act : act;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_n_r);
    model_step(1, rst_n_f);
    #1;
  endtask

  task automatic sync_start(input int d);
    ia[d] = (d == 1) ? '1 : '0;
    ib[d] = (d == 1) ? '1 : '0;
    isync[d] = 1'b1;
    tick();
    isync[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_r = 1'b0;
    rst_n_f = 1'b0;
    ia[0] = '0; ib[0] = '0; ia[1] = '1; ib[1] = '1;
    isync[0] = 1'b0; isync[1] = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    tick();
    tick();
    n_total++; if (if_r.q !== 4'h0) $display("FAIL reset_q_r: got %h exp 0", if_r.q); else n_pass++;
    n_total++; if (if_f.q !== 4'hF) $display("FAIL reset_q_f: got %h exp F", if_f.q); else n_pass++;
    n_total++; if (if_r.gamma_cnt !== 4'd0) $display("FAIL reset_cnt_r: got %0d exp 0", if_r.gamma_cnt); else n_pass++;
    n_total++; if (if_f.gamma_cnt !== 4'd0) $display("FAIL reset_cnt_f: got %0d exp 0", if_f.gamma_cnt); else n_pass++;
    n_total++; if (if_r.gamma_last !== 1'b0) $display("FAIL reset_last: got %b exp 0", if_r.gamma_last); else n_pass++;
`ifdef STC_LT_TIMESTAMP_EN
    n_total++; if (if_r.t_valid !== 4'h0 || if_r.t_fire !== 16'h0)
      $display("FAIL reset_ts: got v=%h t=%h exp 0", if_r.t_valid, if_r.t_fire); else n_pass++;
`endif
    rst_n_r = 1'b1;
    rst_n_f = 1'b1;
    tick();
    n_total++; if (if_r.gamma_cnt !== 4'd1) $display("FAIL first_inc_r: got %0d exp 1", if_r.gamma_cnt); else n_pass++;
    n_total++; if (if_f.gamma_cnt !== 4'd1) $display("FAIL first_inc_f: got %0d exp 1", if_f.gamma_cnt); else n_pass++;
  endtask

  task automatic test_pass_block_tie();
    int c, w, c1, w1;
    logic [N-1:0] eq;
    sync_start(0);
    for (int k = 0; k < 40; k++) begin
      c = k % 16; w = k / 16;
      ia[0][0] = (w == 0 && c >= 3);
      ib[0][0] = (w == 0 && c >= 7);
      ia[0][1] = (w == 0 && c >= 5) || (w == 1 && c == 15) || (w == 2);
      ib[0][1] = (w == 0 && c >= 2);
      ia[0][2] = (w == 0 && c >= 6);
      ib[0][2] = (w == 0 && c >= 6);
      ia[0][3] = (w == 0 && c >= 14) || (w >= 1);
      ib[0][3] = 1'b0;
      tick();
      c1 = (k + 1) % 16; w1 = (k + 1) / 16;
      eq[0] = (w1 == 0 && c1 >= 4 && c1 <= 7);
      eq[1] = 1'b0;
      eq[2] = (w1 == 0 && c1 >= 7 && c1 <= 10);
      eq[3] = (w1 == 0 && c1 == 15);
      n_total++; if (if_r.q !== eq) $display("FAIL ltq k=%0d: got %b exp %b", k, if_r.q, eq); else n_pass++;
      n_total++; if (if_r.gamma_cnt !== GW'(c1)) $display("FAIL ltcnt k=%0d: got %0d exp %0d", k, if_r.gamma_cnt, c1); else n_pass++;
      n_total++; if (if_r.gamma_last !== (c1 == 15)) $display("FAIL ltlast k=%0d: got %b", k, if_r.gamma_last); else n_pass++;
`ifdef STC_LT_TIMESTAMP_EN
      if (w1 == 0 && c1 == 8) begin
        n_total++; if (if_r.t_valid !== 4'b0101 || if_r.t_fire[3:0] !== 4'd3 || if_r.t_fire[11:8] !== 4'd6)
          $display("FAIL ts_capture: got v=%b t=%h exp v=0101 t0=3 t2=6", if_r.t_valid, if_r.t_fire); else n_pass++;
      end
      if (w1 == 1 && c1 == 0) begin
        n_total++; if (if_r.t_valid !== 4'h0 || if_r.t_fire !== 16'h0)
          $display("FAIL ts_clear: got v=%b t=%h exp 0", if_r.t_valid, if_r.t_fire); else n_pass++;
      end
`endif
    end
  endtask

  task automatic test_reset_mid_pulse();
    sync_start(0);
    for (int k = 0; k < 5; k++) begin
      ia[0][0] = (k >= 3);
      tick();
    end
    n_total++; if (if_r.q[0] !== 1'b1) $display("FAIL pre_rst_q0: got %b exp 1", if_r.q[0]); else n_pass++;
    #2;
    rst_n_r = 1'b0;
    #1;
    n_total++; if (if_r.q !== 4'h0) $display("FAIL async_rst_q: got %h exp 0", if_r.q); else n_pass++;
    n_total++; if (if_r.gamma_cnt !== 4'd0) $display("FAIL async_rst_cnt: got %0d exp 0", if_r.gamma_cnt); else n_pass++;
    ia[0] = '0;
    tick();
    rst_n_r = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ia[0][0] = (k >= 2);
      tick();
      n_total++; if (if_r.q !== {3'b000, (k + 1 >= 3 && k + 1 <= 6)})
        $display("FAIL post_rst_q k=%0d: got %b", k, if_r.q); else n_pass++;
      n_total++; if (if_r.gamma_cnt !== GW'(k + 1))
        $display("FAIL post_rst_cnt k=%0d: got %0d exp %0d", k, if_r.gamma_cnt, k + 1); else n_pass++;
    end
  endtask

  task automatic test_falling();
    int ec, win;
    bit act;
    sync_start(1);
    ec = 0; win = 0;
    for (int k = 0; k < 26; k++) begin
      ia[1] = '1; ib[1] = '1; isync[1] = 1'b0;
      if (win == 0) begin
        ia[1][0] = !(ec >= 4 && ec < 14);
        ib[1][0] = !(ec >= 9 && ec < 14);
      end else if (win == 1) begin
        ia[1][0] = !(ec >= 4);
        isync[1] = (ec == 6);
      end else begin
        ia[1][0] = 1'b0;
      end
      tick();
      if (isync[1] || ec == G - 1) begin ec = 0; win++; end
      else ec++;
      act = (win == 0 && ec >= 5 && ec <= 8) || (win == 1 && ec >= 5 && ec <= 6);
      n_total++; if (if_f.q !== {3'b111, !act}) $display("FAIL fall_q k=%0d: got %b exp %b", k, if_f.q, {3'b111, !act}); else n_pass++;
      n_total++; if (if_f.gamma_cnt !== GW'(ec)) $display("FAIL fall_cnt k=%0d: got %0d exp %0d", k, if_f.gamma_cnt, ec); else n_pass++;
    end
    isync[1] = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] qa;
    logic [GW-1:0] ca;
    logic la;
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(7) == 0) ia[d][i] = ~ia[d][i];
          if ($urandom_range(7) == 0) ib[d][i] = ~ib[d][i];
        end
        isync[d] = ($urandom_range(39) == 0);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        qa = (d == 0) ? if_r.q : if_f.q;
        ca = (d == 0) ? if_r.gamma_cnt : if_f.gamma_cnt;
        la = (d == 0) ? if_r.gamma_last : if_f.gamma_last;
        n_total++; if (qa !== exp_q(d)) $display("FAIL rand_q d=%0d k=%0d: got %b exp %b", d, k, qa, exp_q(d)); else n_pass++;
        n_total++; if (ca !== GW'(mcnt[d])) $display("FAIL rand_cnt d=%0d k=%0d: got %0d exp %0d", d, k, ca, mcnt[d]); else n_pass++;
        n_total++; if (la !== (mcnt[d] == G - 1)) $display("FAIL rand_last d=%0d k=%0d: got %b", d, k, la); else n_pass++;
`ifdef STC_LT_TIMESTAMP_EN
        for (int i = 0; i < N; i++) begin
          logic [GW-1:0] tf;
          logic tv;
          tf = (d == 0) ? if_r.t_fire[i*GW +: GW] : if_f.t_fire[i*GW +: GW];
          tv = (d == 0) ? if_r.t_valid[i] : if_f.t_valid[i];
          n_total++; if (tv !== mpass(d, i) || tf !== (mpass(d, i) ? GW'(mtf[d][i]) : '0))
            $display("FAIL rand_ts d=%0d ch=%0d k=%0d: got v=%b t=%0d", d, i, k, tv, tf); else n_pass++;
        end
`endif
      end
    end
    isync[0] = 1'b0;
    isync[1] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pass_block_tie();
    test_reset_mid_pulse();
    test_falling();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
